// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: two-master round-robin arbiter and master mux for the
// shared cache/memory bus. Optional watchdog: define BUS_ARB_TIMEOUT_EN.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   m0_bus_* / m1_bus_* master side: req in, gnt out (registered),
//                       address/dataout/rd/wr in, datain/ready out
//   s_bus_*             slave side: address/datain/rd/wr out,
//                       dataout/ready in
//   arb_timeout         1-cycle watchdog pulse (BUS_ARB_TIMEOUT_EN only)
module bus_arbiter_rr #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_ADR_WIDTH  = 14
`ifdef BUS_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      m0_bus_req,
  output logic                      m0_bus_gnt,
  input  logic [BUS_ADR_WIDTH-1:0]  m0_bus_address,
  input  logic [BUS_DATA_WIDTH-1:0] m0_bus_dataout,
  output logic [BUS_DATA_WIDTH-1:0] m0_bus_datain,
  input  logic                      m0_bus_rd,
  input  logic                      m0_bus_wr,
  output logic                      m0_bus_ready,

  input  logic                      m1_bus_req,
  output logic                      m1_bus_gnt,
  input  logic [BUS_ADR_WIDTH-1:0]  m1_bus_address,
  input  logic [BUS_DATA_WIDTH-1:0] m1_bus_dataout,
  output logic [BUS_DATA_WIDTH-1:0] m1_bus_datain,
  input  logic                      m1_bus_rd,
  input  logic                      m1_bus_wr,
  output logic                      m1_bus_ready,

  output logic [BUS_ADR_WIDTH-1:0]  s_bus_address,
  output logic [BUS_DATA_WIDTH-1:0] s_bus_datain,
  input  logic [BUS_DATA_WIDTH-1:0] s_bus_dataout,
  output logic                      s_bus_rd,
  output logic                      s_bus_wr,
  input  logic                      s_bus_ready
`ifdef BUS_ARB_TIMEOUT_EN
  ,
  output logic                      arb_timeout
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state_q, state_d;

  // 0: master 0 wins a tie in IDLE, 1: master 1 wins
  logic ptr_q, ptr_d;

  logic elig0, elig1;
  logic tmo_hit;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_q;
  logic          blk0_q, blk1_q;
  logic          stall;

  assign stall = (state_q != IDLE)
               && (s_bus_rd || s_bus_wr)
               && !s_bus_ready;

  // Counter holds the cycles already stalled; this stall is the last one.
  assign tmo_hit = stall && (wd_q == CW'(TIMEOUT_CYCLES - 1));

  // A master just forced off sits out one arbitration round.
  assign elig0 = m0_bus_req && !blk0_q;
  assign elig1 = m1_bus_req && !blk1_q;
`else
  assign tmo_hit = 1'b0;
  assign elig0   = m0_bus_req;
  assign elig1   = m1_bus_req;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (elig0 && (!elig1 || !ptr_q)) begin
          state_d = OWN0;
        end else if (elig1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!m0_bus_req) begin
          ptr_d   = 1'b1;
          state_d = m1_bus_req ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_bus_req) begin
          ptr_d   = 1'b0;
          state_d = m0_bus_req ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tmo_hit) begin
      state_d = IDLE;
      ptr_d   = (state_q == OWN0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q        <= '0;
      arb_timeout <= 1'b0;
      blk0_q      <= 1'b0;
      blk1_q      <= 1'b0;
    end else begin
      arb_timeout <= tmo_hit;
      blk0_q      <= tmo_hit && (state_q == OWN0);
      blk1_q      <= tmo_hit && (state_q == OWN1);
      if (tmo_hit || (state_d != state_q) || s_bus_ready) begin
        wd_q <= '0;
      end else if (stall) begin
        wd_q <= wd_q + CW'(1);
      end
    end
  end
`endif

  assign m0_bus_gnt = (state_q == OWN0);
  assign m1_bus_gnt = (state_q == OWN1);

  // Mux decoded straight from the state register so an async reset
  // drops the slave strobes without waiting for an edge.
  always_comb begin
    s_bus_address = '0;
    s_bus_datain  = '0;
    s_bus_rd      = 1'b0;
    s_bus_wr      = 1'b0;
    unique case (1'b1)
      m0_bus_gnt: begin
        s_bus_address = m0_bus_address;
        s_bus_datain  = m0_bus_dataout;
        s_bus_rd      = m0_bus_rd;
        s_bus_wr      = m0_bus_wr;
      end
      m1_bus_gnt: begin
        s_bus_address = m1_bus_address;
        s_bus_datain  = m1_bus_dataout;
        s_bus_rd      = m1_bus_rd;
        s_bus_wr      = m1_bus_wr;
      end
      default: begin
        s_bus_address = '0;
      end
    endcase
  end

  assign m0_bus_datain = s_bus_dataout;
  assign m1_bus_datain = s_bus_dataout;
  assign m0_bus_ready  = s_bus_ready && m0_bus_gnt;
  assign m1_bus_ready  = s_bus_ready && m1_bus_gnt;

endmodule
